// File: rtl/code_loader_pkg.sv
// Shared types and frame layout for the byte-stream code loader.
package code_loader_pkg;

    // One state per frame field; DATA_L/DATA_H repeat once per word.
    typedef enum logic [2:0] {
        StIdle,
        StAddrL,
        StAddrH,
        StCntL,
        StCntH,
        StDataL,
        StDataH,
        StCsum
    } state_e;

    localparam logic [7:0] MagicDefault = 8'hA5;

    // Byte offsets of the fixed frame fields; data words start at OffData.
    localparam int OffMagic = 0;
    localparam int OffAddrL = 1;
    localparam int OffAddrH = 2;
    localparam int OffCntL  = 3;
    localparam int OffCntH  = 4;
    localparam int OffData  = 5;

    // Total frame length in bytes for a given word count (header + data + checksum).
    function automatic int frame_len(input int n_words);
        return OffData + 2 * n_words + 1;
    endfunction

endpackage

// File: rtl/code_loader_timeout.sv
// Idle counter for an in-progress frame: counts while enabled, clears on every
// accepted byte, and flags expiry on the cycle whose edge brings it to the limit.
module code_loader_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Count value one below the limit; the next increment reaches TIMEOUT_CYCLES.
    localparam logic [31:0] Last = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] count_q, count_d;

    // Next count: held at zero outside a frame and on accepted bytes.
    always_comb begin
        count_d = count_q + 32'd1;
        if (clear || !enable) begin
            count_d = '0;
        end
    end

    // A clear in the same cycle cancels expiry, so an arriving byte always wins.
    assign expired = enable && !clear && (count_q == Last);

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/code_loader.sv
// Framed byte-stream loader driving the CPU code memory write port. Assembles
// little-endian 16-bit words, writes them at consecutive (wrapping) addresses,
// holds the CPU in reset during a frame and reports checksum/timeout status.
module code_loader
    import code_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 16,  // two bytes per word; must stay 16
    parameter int unsigned ADDR_WIDTH     = 8,   // at most 16
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  MAGIC          = MagicDefault
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr_w,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  err_checksum,
    output logic                  err_timeout
);

    state_e                state_q, state_d;
    logic [7:0]            lo_q, lo_d;      // low byte of the field being assembled
    logic [7:0]            sum_q, sum_d;
    logic [15:0]           cnt_q, cnt_d;    // words still to receive
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;  // address of the next word
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    logic                  done_q, done_d;
    logic                  err_csum_q, err_csum_d;
    logic                  err_to_q, err_to_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  accept;
    logic                  expired;

    assign in_ready = !reset;
    assign accept   = in_valid && in_ready;

    code_loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept),
        .enable (state_q != StIdle),
        .expired(expired)
    );

    // Frame parser: next state, field assembly, checksum and registered outputs.
    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        done_d      = 1'b0;
        err_csum_d  = err_csum_q;
        err_to_d    = err_to_q;

        if (accept) begin
            // Every byte between MAGIC and CSUM contributes to the sum.
            if (state_q != StIdle && state_q != StCsum) begin
                sum_d = sum_q + in_data;
            end
            unique case (state_q)
                StIdle: begin
                    if (in_data == MAGIC) begin
                        state_d    = StAddrL;
                        sum_d      = '0;
                        err_csum_d = 1'b0;
                        err_to_d   = 1'b0;
                    end
                end
                StAddrL: begin
                    lo_d    = in_data;
                    state_d = StAddrH;
                end
                StAddrH: begin
                    addr_d  = ADDR_WIDTH'({in_data, lo_q});
                    state_d = StCntL;
                end
                StCntL: begin
                    lo_d    = in_data;
                    state_d = StCntH;
                end
                StCntH: begin
                    cnt_d   = {in_data, lo_q};
                    state_d = ({in_data, lo_q} == 16'd0) ? StCsum : StDataL;
                end
                StDataL: begin
                    lo_d    = in_data;
                    state_d = StDataH;
                end
                StDataH: begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = addr_q;
                    mem_data_d = DATA_WIDTH'({in_data, lo_q});
                    addr_d     = addr_q + ADDR_WIDTH'(1);
                    cnt_d      = cnt_q - 16'd1;
                    state_d    = (cnt_q == 16'd1) ? StCsum : StDataL;
                end
                StCsum: begin
                    err_csum_d = (sum_q != in_data);
                    done_d     = 1'b1;
                    state_d    = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end else if (expired) begin
            state_d  = StIdle;
            err_to_d = 1'b1;
            done_d   = 1'b1;
        end

        cpu_reset_d = (state_d != StIdle);
    end

    // State and output registers; reset abandons any frame without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            lo_q        <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            done_q      <= 1'b0;
            err_csum_q  <= 1'b0;
            err_to_q    <= 1'b0;
            cpu_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            done_q      <= done_d;
            err_csum_q  <= err_csum_d;
            err_to_q    <= err_to_d;
            cpu_reset_q <= cpu_reset_d;
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr_w   = mem_addr_q;
    assign mem_data     = mem_data_q;
    assign done         = done_q;
    assign err_checksum = err_csum_q;
    assign err_timeout  = err_to_q;
    assign cpu_reset    = cpu_reset_q;

endmodule

// File: tb/tb_code_loader.sv
// Self-checking bench for code_loader: table of whole frames plus directed
// sequences for timeout, byte-beats-timeout and mid-frame reset.
module tb_code_loader;
    import code_loader_pkg::*;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [7:0]  mem_addr_w;
    logic [15:0] mem_data;
    logic        mem_we;
    logic        cpu_reset;
    logic        done;
    logic        err_checksum;
    logic        err_timeout;

    code_loader #(
        .DATA_WIDTH    (16),
        .ADDR_WIDTH    (8),
        .TIMEOUT_CYCLES(TO),
        .MAGIC         (8'hA5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .mem_addr_w  (mem_addr_w),
        .mem_data    (mem_data),
        .mem_we      (mem_we),
        .cpu_reset   (cpu_reset),
        .done        (done),
        .err_checksum(err_checksum),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] start;
        int          nw;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [7:0]  csum;
        logic [7:0]  a0;    // expected write addresses
        logic [7:0]  a1;
        logic        err;   // expected err_checksum
    } vec_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] fr [0:15];

    function automatic vec_t mkv(input logic [15:0] start, input int nw, input logic [15:0] w0,
                                 input logic [15:0] w1, input logic [7:0] csum,
                                 input logic [7:0] a0, input logic [7:0] a1, input logic err);
        vec_t v;
        v.start = start; v.nw = nw; v.w0 = w0; v.w1 = w1; v.csum = csum;
        v.a0 = a0; v.a1 = a1; v.err = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lay out a frame's bytes from its fields.
    task automatic build(input vec_t v);
        fr[OffMagic] = 8'hA5;
        fr[OffAddrL] = v.start[7:0];
        fr[OffAddrH] = v.start[15:8];
        fr[OffCntL]  = 8'(v.nw);
        fr[OffCntH]  = 8'h00;
        if (v.nw > 0) begin
            fr[OffData]     = v.w0[7:0];
            fr[OffData + 1] = v.w0[15:8];
        end
        if (v.nw > 1) begin
            fr[OffData + 2] = v.w1[7:0];
            fr[OffData + 3] = v.w1[15:8];
        end
        fr[frame_len(v.nw) - 1] = v.csum;
    endtask

    // Send fr[first..last] one byte per cycle, checking outputs after each accept.
    task automatic send_range(input vec_t v, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            bit is_last;
            bit is_wr;
            int k;
            in_valid = 1'b1;
            in_data  = fr[i];
            tick();
            is_last = (i == frame_len(v.nw) - 1);
            k       = (i - OffData) / 2;
            is_wr   = (i > OffData) && (((i - OffData) % 2) == 1) && (k < v.nw);
            check("cpu_reset", 32'(cpu_reset), 32'(!is_last));
            check("done", 32'(done), 32'(is_last));
            check("mem_we", 32'(mem_we), 32'(is_wr));
            if (is_wr) begin
                check("mem_addr_w", 32'(mem_addr_w), 32'((k == 0) ? v.a0 : v.a1));
                check("mem_data", 32'(mem_data), 32'((k == 0) ? v.w0 : v.w1));
            end
            if (is_last) begin
                check("err_checksum", 32'(err_checksum), 32'(v.err));
                check("err_timeout", 32'(err_timeout), 32'd0);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic idle_after_frame(input logic exp_err);
        tick();
        check("done_idle", 32'(done), 32'd0);
        check("cpu_reset_idle", 32'(cpu_reset), 32'd0);
        check("mem_we_idle", 32'(mem_we), 32'd0);
        check("err_checksum_sticky", 32'(err_checksum), 32'(exp_err));
    endtask

    vec_t vecs [8];
    vec_t vt;

    initial begin
        // Byte sum of 10 00 02 00 34 12 78 56 is 0x26, so CE is a mismatch.
        vecs[0] = mkv(16'h0010, 2, 16'h1234, 16'h5678, 8'h26, 8'h10, 8'h11, 1'b0);
        vecs[1] = mkv(16'h0010, 2, 16'h1234, 16'h5678, 8'h00, 8'h10, 8'h11, 1'b1);
        vecs[2] = mkv(16'h0010, 2, 16'h1234, 16'h5678, 8'hCE, 8'h10, 8'h11, 1'b1);
        vecs[3] = mkv(16'h0010, 2, 16'h1234, 16'h5678, 8'h26, 8'h10, 8'h11, 1'b0);
        vecs[4] = mkv(16'h00FF, 2, 16'hAAAA, 16'hBBBB, 8'hCB, 8'hFF, 8'h00, 1'b0);
        vecs[5] = mkv(16'h0000, 0, 16'h0000, 16'h0000, 8'h00, 8'h00, 8'h00, 1'b0);
        vecs[6] = mkv(16'h0720, 1, 16'hBEEF, 16'h0000, 8'hD5, 8'h20, 8'h00, 1'b0);
        vecs[7] = mkv(16'h0030, 1, 16'hA5A5, 16'h0000, 8'h7B, 8'h30, 8'h00, 1'b0);

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr_w", 32'(mem_addr_w), 32'd0);
        check("rst_mem_data", 32'(mem_data), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err_checksum", 32'(err_checksum), 32'd0);
        check("rst_err_timeout", 32'(err_timeout), 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        reset = 1'b0;
        #1;
        check("in_ready_after_rst", 32'(in_ready), 32'd1);
        tick();
        check("cpu_reset_release", 32'(cpu_reset), 32'd0);

        // Whole frames from the table.
        for (int t = 0; t < 8; t++) begin
            build(vecs[t]);
            send_range(vecs[t], 0, frame_len(vecs[t].nw) - 1);
            idle_after_frame(vecs[t].err);
        end

        // Timeout: stall after CNT_H.
        vt = mkv(16'h0010, 1, 16'h1234, 16'h0000, 8'h57, 8'h10, 8'h00, 1'b0);
        build(vt);
        send_range(vt, 0, OffCntH);
        for (int c = 1; c < int'(TO); c++) begin
            tick();
            check("to_no_done_early", 32'(done), 32'd0);
            check("to_cpu_reset_held", 32'(cpu_reset), 32'd1);
        end
        tick();
        check("to_done", 32'(done), 32'd1);
        check("to_err_timeout", 32'(err_timeout), 32'd1);
        check("to_cpu_reset_fall", 32'(cpu_reset), 32'd0);
        check("to_err_checksum", 32'(err_checksum), 32'd0);
        tick();
        check("to_done_one_cycle", 32'(done), 32'd0);
        check("to_err_timeout_sticky", 32'(err_timeout), 32'd1);
        in_valid = 1'b1;
        in_data  = 8'h3C;
        tick();
        in_valid = 1'b0;
        check("junk_ignored_cpu_reset", 32'(cpu_reset), 32'd0);
        send_range(vt, 0, frame_len(vt.nw) - 1);
        idle_after_frame(1'b0);

        // Byte arrives on the very cycle the idle count would expire.
        build(vt);
        send_range(vt, 0, OffCntH);
        for (int c = 1; c < int'(TO); c++) begin
            tick();
        end
        check("race_no_done", 32'(done), 32'd0);
        send_range(vt, OffData, frame_len(vt.nw) - 1);
        idle_after_frame(1'b0);
        check("race_err_timeout", 32'(err_timeout), 32'd0);

        // Reset between DATA_L and DATA_H, after a bad-checksum frame.
        build(vecs[1]);
        send_range(vecs[1], 0, frame_len(vecs[1].nw) - 1);
        idle_after_frame(1'b1);
        vt = mkv(16'h0040, 1, 16'h2211, 16'h0000, 8'h00, 8'h40, 8'h00, 1'b0);
        build(vt);
        send_range(vt, 0, OffData);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h22;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("mid_rst_no_write", 32'(mem_we), 32'd0);
        check("mid_rst_no_done", 32'(done), 32'd0);
        check("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();
        check("post_rst_cpu_reset", 32'(cpu_reset), 32'd0);
        check("post_rst_mem_we", 32'(mem_we), 32'd0);
        check("post_rst_done", 32'(done), 32'd0);
        check("post_rst_err_checksum", 32'(err_checksum), 32'd0);
        check("post_rst_err_timeout", 32'(err_timeout), 32'd0);
        tick();
        check("post_rst_mem_we2", 32'(mem_we), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
